// File: rtl/queue_msg_reader.sv
// -----------------------------------------------------------------------------
// queue_msg_reader
//
// Drains a first-word-fall-through queue of 32-bit words, frames them into
// messages using a length field carried in each header word, and presents the
// words on a registered valid/ready stream with start/end-of-message markers.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   q_dout     - queue head word, valid while q_empty is low
//   q_empty    - queue empty flag
//   q_rd_en    - pop strobe for the queue head (combinational)
//   en         - permits starting a new message; sampled only at a header
//   m_data     - output beat data
//   m_valid    - output beat valid
//   m_ready    - downstream accepts the beat when valid & ready
//   m_sop      - beat is a header word
//   m_eop      - beat is the last word of its message
//   busy       - a message is partially popped (payload words outstanding)
//   msg_count  - completed messages (statistics build only, else 0)
//   word_count - words popped (statistics build only, else 0)
//
// Build option:
//   QUEUE_MSG_READER_STATS_EN - when defined, the wrapping 16-bit message and
//   word counters are built; when undefined both count outputs are tied to 0.
// -----------------------------------------------------------------------------
module queue_msg_reader #(
    parameter int LEN_LSB = 20,
    parameter int LEN_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] q_dout,
    input  logic        q_empty,
    output logic        q_rd_en,
    input  logic        en,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sop,
    output logic        m_eop,
    output logic        busy,
    output logic [15:0] msg_count,
    output logic [15:0] word_count
);

    typedef enum logic {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   rem_q;
    logic [31:0]        m_data_q;
    logic               m_valid_q;
    logic               m_sop_q;
    logic               m_eop_q;

    logic               slot_free;
    logic [LEN_W-1:0]   hdr_len;
    logic               pop_eop;

    // The output register can take a new word when it is empty or its current
    // beat is being accepted in this same cycle.
    assign slot_free = !m_valid_q || m_ready;
    assign hdr_len   = q_dout[LEN_LSB +: LEN_W];

    // A popped word ends its message if it is a zero-length header or the last
    // outstanding payload word.
    assign pop_eop   = (state_q == ST_HDR) ? (hdr_len == '0) : (rem_q == LEN_W'(1));

    // en only gates the start of a message; payload drains regardless.
    assign q_rd_en   = !q_empty && slot_free && ((state_q == ST_PAYLOAD) || en);

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HDR;
            rem_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_sop_q   <= 1'b0;
            m_eop_q   <= 1'b0;
        end else if (q_rd_en) begin
            m_data_q  <= q_dout;
            m_valid_q <= 1'b1;
            m_eop_q   <= pop_eop;
            if (state_q == ST_HDR) begin
                m_sop_q <= 1'b1;
                if (hdr_len != '0) begin
                    rem_q   <= hdr_len;
                    state_q <= ST_PAYLOAD;
                end
            end else begin
                m_sop_q <= 1'b0;
                rem_q   <= rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_q <= ST_HDR;
                end
            end
        end else if (m_ready) begin
            // Beat accepted with nothing to replace it: register drains.
            m_valid_q <= 1'b0;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_sop   = m_sop_q;
    assign m_eop   = m_eop_q;
    // Single-bit state encoding, so busy is driven straight from a flop.
    assign busy    = (state_q == ST_PAYLOAD);

`ifdef QUEUE_MSG_READER_STATS_EN
    logic [15:0] msg_count_q, msg_count_d;
    logic [15:0] word_count_q, word_count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        msg_count_d  = msg_count_q;
        word_count_d = word_count_q;
        if (q_rd_en) begin
            word_count_d = word_count_q + 16'd1;
            if (pop_eop) begin
                msg_count_d = msg_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            msg_count_q  <= msg_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign msg_count  = msg_count_q;
    assign word_count = word_count_q;
`else
    assign msg_count  = '0;
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_queue_msg_reader.sv
// -----------------------------------------------------------------------------
// tb_queue_msg_reader
//
// Directed bench for queue_msg_reader. A small array-backed FWFT queue model
// feeds the DUT; a monitor logs every accepted output beat, and each scenario
// compares the log and sampled outputs against hand-computed expectations.
// Inputs change on the falling edge; the monitor samples 2 ns later and the
// scenario checks sample 3 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_queue_msg_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] q_dout;
    logic        q_empty;
    logic        q_rd_en;
    logic        en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sop;
    logic        m_eop;
    logic        busy;
    logic [15:0] msg_count;
    logic [15:0] word_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    queue_msg_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_dout     (q_dout),
        .q_empty    (q_empty),
        .q_rd_en    (q_rd_en),
        .en         (en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .busy       (busy),
        .msg_count  (msg_count),
        .word_count (word_count)
    );

    // ---------------- FWFT queue model ----------------
    logic [31:0] mem [0:511];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign q_empty = (rd_ptr == wr_ptr);
    assign q_dout  = mem[rd_ptr[8:0]];

    // Queue is reset together with the DUT, discarding unread words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rd_ptr <= wr_ptr;
        else if (q_rd_en) rd_ptr <= rd_ptr + 1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[8:0]] = w;
        wr_ptr++;
    endtask

    // ---------------- output monitor ----------------
    logic [31:0] b_data [0:511];
    logic        b_sop  [0:511];
    logic        b_eop  [0:511];
    int          b_cyc  [0:511];
    int          n_beats     = 0;
    int          cyc         = 0;
    int          busy_cycles = 0;
    int          rd_en_cycles = 0;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (busy)    busy_cycles++;
        if (q_rd_en) rd_en_cycles++;
        if (m_valid && m_ready) begin
            b_data[n_beats] = m_data;
            b_sop[n_beats]  = m_sop;
            b_eop[n_beats]  = m_eop;
            b_cyc[n_beats]  = cyc;
            n_beats++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] d,
                              input logic s, input logic e);
        check($sformatf("%s_data%0d", tag, idx), b_data[idx], d);
        check($sformatf("%s_sop%0d", tag, idx), {31'd0, b_sop[idx]}, {31'd0, s});
        check($sformatf("%s_eop%0d", tag, idx), {31'd0, b_eop[idx]}, {31'd0, e});
    endtask

    // Waits (bounded) until the monitor has logged `target` beats.
    task automatic wait_beats(input int target, input string tag);
        int k;
        k = 0;
        while (n_beats < target && k < 200) begin
            @(negedge clk);
            #3;
            k++;
        end
        check({tag, "_count"}, n_beats, target);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    int base;
    int b0;
    int r0;
    int n_sop;
    int n_eop;

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_sop",   {31'd0, m_sop},   32'd0);
        check("rst_eop",   {31'd0, m_eop},   32'd0);
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_data",  m_data,           32'd0);
        check("rst_msgc",  {16'd0, msg_count},  32'd0);
        check("rst_wordc", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        en      = 1'b1;
        m_ready = 1'b1;

        // ---- single len-3 message ----
        @(negedge clk);
        base = n_beats;
        b0   = busy_cycles;
        push(32'h0030_0000);
        push(32'h0000_000A);
        push(32'h0000_000B);
        push(32'h0000_000C);
        wait_beats(base + 4, "t1");
        check_beat("t1", base + 0, 32'h0030_0000, 1'b1, 1'b0);
        check_beat("t1", base + 1, 32'h0000_000A, 1'b0, 1'b0);
        check_beat("t1", base + 2, 32'h0000_000B, 1'b0, 1'b0);
        check_beat("t1", base + 3, 32'h0000_000C, 1'b0, 1'b1);
        check("t1_consecutive", b_cyc[base + 3] - b_cyc[base], 32'd3);
        idle(2);
        check("t1_busy_cycles", busy_cycles - b0, 32'd3);
`ifdef QUEUE_MSG_READER_STATS_EN
        check("t1_msgc",  {16'd0, msg_count},  32'd1);
        check("t1_wordc", {16'd0, word_count}, 32'd4);
`else
        check("t1_msgc",  {16'd0, msg_count},  32'd0);
        check("t1_wordc", {16'd0, word_count}, 32'd0);
`endif

        // ---- zero-length back-to-back ----
        @(negedge clk);
        base = n_beats;
        b0   = busy_cycles;
        push(32'h0000_0001);
        push(32'h0000_0002);
        wait_beats(base + 2, "t2");
        check_beat("t2", base + 0, 32'h0000_0001, 1'b1, 1'b1);
        check_beat("t2", base + 1, 32'h0000_0002, 1'b1, 1'b1);
        idle(2);
        check("t2_never_busy", busy_cycles - b0, 32'd0);
        check("t2_no_extra", n_beats, base + 2);

        // ---- backpressure on the header beat ----
        @(negedge clk);
        m_ready = 1'b0;
        base = n_beats;
        push(32'h0020_0005);
        push(32'h0000_0011);
        push(32'h0000_0022);
        @(posedge clk);
        r0 = rd_en_cycles;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check($sformatf("t3_hold_data%0d", i), m_data, 32'h0020_0005);
            check($sformatf("t3_hold_valid%0d", i), {31'd0, m_valid}, 32'd1);
            check($sformatf("t3_hold_rden%0d", i), {31'd0, q_rd_en}, 32'd0);
        end
        check("t3_no_pop_in_stall", rd_en_cycles - r0, 32'd0);
        @(negedge clk);
        m_ready = 1'b1;
        wait_beats(base + 3, "t3");
        check_beat("t3", base + 0, 32'h0020_0005, 1'b1, 1'b0);
        check_beat("t3", base + 1, 32'h0000_0011, 1'b0, 1'b0);
        check_beat("t3", base + 2, 32'h0000_0022, 1'b0, 1'b1);
        idle(2);
        check("t3_no_extra", n_beats, base + 3);

        // ---- queue underflow mid-message ----
        @(negedge clk);
        base = n_beats;
        push(32'h0040_0000);
        push(32'h0000_00D1);
        wait_beats(base + 2, "t4a");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check($sformatf("t4_gap_rden%0d", i), {31'd0, q_rd_en}, 32'd0);
            check($sformatf("t4_gap_busy%0d", i), {31'd0, busy},    32'd1);
        end
        @(negedge clk);
        push(32'h0000_00D2);
        push(32'h0000_00D3);
        push(32'h0000_00D4);
        wait_beats(base + 5, "t4b");
        check_beat("t4", base + 0, 32'h0040_0000, 1'b1, 1'b0);
        check_beat("t4", base + 1, 32'h0000_00D1, 1'b0, 1'b0);
        check_beat("t4", base + 2, 32'h0000_00D2, 1'b0, 1'b0);
        check_beat("t4", base + 3, 32'h0000_00D3, 1'b0, 1'b0);
        check_beat("t4", base + 4, 32'h0000_00D4, 1'b0, 1'b1);
        idle(3);
        check("t4_no_extra", n_beats, base + 5);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);

        // ---- en drops mid-message ----
        @(negedge clk);
        base = n_beats;
        push(32'h0020_0000);
        push(32'h0000_00E1);
        push(32'h0000_00E2);
        push(32'h0000_0077);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        wait_beats(base + 3, "t5a");
        check_beat("t5", base + 0, 32'h0020_0000, 1'b1, 1'b0);
        check_beat("t5", base + 1, 32'h0000_00E1, 1'b0, 1'b0);
        check_beat("t5", base + 2, 32'h0000_00E2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check($sformatf("t5_blocked_rden%0d", i), {31'd0, q_rd_en}, 32'd0);
        end
        check("t5_blocked_beats", n_beats, base + 3);
        @(negedge clk);
        en = 1'b1;
        wait_beats(base + 4, "t5b");
        check_beat("t5", base + 3, 32'h0000_0077, 1'b1, 1'b1);

        // ---- maximum length message ----
        @(negedge clk);
        base = n_beats;
        push(32'h03F0_0000);
        for (int i = 1; i <= 63; i++) push(32'h0000_1000 + i);
        wait_beats(base + 64, "t6");
        n_sop = 0;
        n_eop = 0;
        for (int i = 0; i < 64; i++) begin
            if (b_sop[base + i]) n_sop++;
            if (b_eop[base + i]) n_eop++;
        end
        check("t6_sop_total", n_sop, 32'd1);
        check("t6_eop_total", n_eop, 32'd1);
        check_beat("t6", base + 0,  32'h03F0_0000, 1'b1, 1'b0);
        check_beat("t6", base + 32, 32'h0000_1020, 1'b0, 1'b0);
        check_beat("t6", base + 63, 32'h0000_103F, 1'b0, 1'b1);

        // ---- reset in the middle of a message ----
        @(negedge clk);
        base = n_beats;
        push(32'h0050_0000);
        push(32'h0000_00F1);
        push(32'h0000_00F2);
        wait_beats(base + 3, "t7a");
        check("t7_busy_before", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", {31'd0, m_valid}, 32'd0);
        check("t7_rst_sop",   {31'd0, m_sop},   32'd0);
        check("t7_rst_eop",   {31'd0, m_eop},   32'd0);
        check("t7_rst_busy",  {31'd0, busy},    32'd0);
        check("t7_rst_data",  m_data,           32'd0);
        check("t7_rst_msgc",  {16'd0, msg_count},  32'd0);
        check("t7_rst_wordc", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_beats;
        push(32'h0000_0009);
        wait_beats(base + 1, "t7b");
        check_beat("t7", base + 0, 32'h0000_0009, 1'b1, 1'b1);
        idle(2);
        check("t7_hdr_state", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
